// File: rtl/parity_frame_chk.sv
// Frame parity checker: XOR-reduces all beats of a frame, compares against
// the expected parity bit on the last beat, and counts parity errors.
// Params : DATA_W beat width, CNT_W error counter width.
// Ports  : clk, n_rst (async active-low), in_valid/in_data/in_last/in_par
//          beat input, odd_mode parity sense, err_clr counter clear,
//          out_valid/out_par/out_err result, err_cnt error count.
// Macro  : PARITY_ERR_CNT_EN compiles in the error counter; without it
//          err_cnt is tied to 0 and err_clr is ignored.
module parity_frame_chk #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_par,
    input  logic              odd_mode,
    input  logic              err_clr,
    output logic              out_valid,
    output logic              out_par,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t state;
    logic   acc;
    logic   mode_q;

    logic beat_par;
    logic frame_par;
    logic frame_mode;
    logic res_par;
    logic res_err;

    // In IDLE the current beat opens the frame, so the accumulator and the
    // latched mode are bypassed in favour of the live values.
    always_comb begin
        beat_par   = ^in_data;
        frame_par  = (state == IDLE) ? beat_par : (acc ^ beat_par);
        frame_mode = (state == IDLE) ? odd_mode : mode_q;
        res_par    = frame_par ^ frame_mode;
        res_err    = res_par ^ in_par;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            acc       <= 1'b0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            out_par   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                unique case (state)
                    IDLE: begin
                        mode_q <= odd_mode;
                        if (in_last) begin
                            acc       <= 1'b0;
                            out_valid <= 1'b1;
                            out_par   <= res_par;
                            out_err   <= res_err;
                        end else begin
                            acc   <= beat_par;
                            state <= ACC;
                        end
                    end
                    ACC: begin
                        if (in_last) begin
                            acc       <= 1'b0;
                            state     <= IDLE;
                            out_valid <= 1'b1;
                            out_par   <= res_par;
                            out_err   <= res_err;
                        end else begin
                            acc <= frame_par;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Clear wins over a same-cycle increment; the count saturates.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (err_clr) begin
            cnt_q <= '0;
        end else if (in_valid && in_last && res_err && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign err_cnt = cnt_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: doc/parity_frame_chk.md
PARITY_FRAME_CHK -- requirements
Module: parity_frame_chk

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the data beat width in bits (legal range 1..64).
REQ-002 SHALL have parameter CNT_W, default 8, giving the error counter width in bits (legal range 1..32).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port n_rst, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, a beat is presented this cycle.
REQ-006 SHALL have port in_data, input, DATA_W, the beat payload.
REQ-007 SHALL have port in_last, input, 1, the final beat of the frame; qualified by in_valid.
REQ-008 SHALL have port in_par, input, 1, the expected parity bit; sampled only on the last beat.
REQ-009 SHALL have port odd_mode, input, 1, selecting the parity sense: 0 even, 1 odd.
REQ-010 SHALL have port err_clr, input, 1, a synchronous clear of the error counter.
REQ-011 SHALL have port out_valid, output, 1, a one-cycle result strobe.
REQ-012 SHALL have port out_par, output, 1, the computed frame parity bit.
REQ-013 SHALL have port out_err, output, 1, flagging that out_par differs from in_par; valid only with out_valid.
REQ-014 SHALL have port err_cnt, output, CNT_W, the count of frames with a parity error.

Function
REQ-015 SHALL accept a beat in every cycle with in_valid=1; there is no backpressure.
REQ-016 SHALL implement the FSM states IDLE and ACC.
REQ-017 SHALL transition IDLE->ACC on in_valid & ~in_last, ACC->IDLE on in_valid & in_last, and otherwise hold state.
REQ-018 SHALL latch odd_mode on the first beat of a frame (any in_valid in IDLE) and use it for the whole frame; changes to odd_mode mid-frame are ignored.
REQ-019 SHALL compute the frame parity as the XOR-reduce of all bits of all accepted beats; out_par = that value XOR the latched odd_mode.
REQ-020 SHALL ignore cycles with in_valid=0 in either state; the accumulator and state hold.
REQ-021 SHALL register out_valid=1 in the cycle after the last beat is accepted, with out_par and out_err = (out_par != in_par).
REQ-022 SHALL hold out_par and out_err stable after out_valid deasserts, until the next result.
REQ-023 SHALL treat a single-beat frame (in_valid & in_last in IDLE) as a complete frame and produce a result one cycle later.
REQ-024 SHALL clear the accumulator when a frame completes, so that a new frame may start in the very next cycle (back-to-back frames, no bubble).
REQ-025 SHALL increment err_cnt by 1 in the same cycle out_err is registered as 1.
REQ-026 SHALL saturate err_cnt at 2^CNT_W-1 with no wrap-around.
REQ-027 SHALL give err_clr priority over a simultaneous increment, so that err_cnt becomes 0.

Reset
REQ-028 SHALL, while n_rst=0, immediately force state=IDLE, accumulator=0, out_valid=0, out_par=0, out_err=0 and err_cnt=0.
REQ-029 SHALL discard a frame interrupted by reset with no result; the first beat after release starts a new frame.

Configuration
REQ-030 SHALL compile in the error counter when macro PARITY_ERR_CNT_EN is defined, with err_cnt behaving as in REQ-025..027.
REQ-031 SHALL, when PARITY_ERR_CNT_EN is undefined, omit the counter logic, tie err_cnt to constant 0 and ignore err_clr; all other behaviour is identical.

Verification (DATA_W=4)
REQ-032 SHALL cover: odd_mode=0, frame 4'b0010, 4'b0011, 4'b0111 (last), in_par=0 -> one cycle later out_valid=1, out_par=0, out_err=0, err_cnt unchanged.
REQ-033 SHALL cover: single beat 4'b0111 with last, odd_mode=1, in_par=1 -> out_par=0, out_err=1, err_cnt +1.
REQ-034 SHALL cover: the same 3-beat frame with in_valid=0 gaps between beats, and odd_mode toggled mid-frame -> result identical to REQ-032.
REQ-035 SHALL cover: n_rst pulsed low after beat 2 of a frame, then a single beat 4'b0001 with last and in_par=1 -> no result for the aborted frame; out_par=1, out_err=0.
REQ-036 SHALL cover: CNT_W=2, four erroneous frames back-to-back -> err_cnt 1,2,3,3; then err_clr together with a fifth error -> err_cnt=0.
REQ-037 SHALL cover: a build without PARITY_ERR_CNT_EN running REQ-033 -> out_err=1 and err_cnt stays 0.
